sprite_motion_ctrl: RTL and testbench



---
 rtl/sprite_motion_ctrl_pkg.sv | 11 +
 rtl/sprite_motion_ctrl_btn_sync.sv | 14 +
 rtl/sprite_motion_ctrl.sv | 120 ++++++++++++
 tb/tb_sprite_motion_ctrl.sv | 132 +++++++++++++
 4 files changed

// File: rtl/sprite_motion_ctrl_pkg.sv
// sprite_motion_ctrl_pkg: shared direction/state encodings and wall-bound helpers
package sprite_motion_ctrl_pkg;
  typedef enum logic [2:0] {DIR_NONE, DIR_U, DIR_D, DIR_L, DIR_R} dir_t;
  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_REPEAT} state_t;
  function automatic int bound_lo(input int wall, input int half);
    return wall + half;
  endfunction
  function automatic int bound_hi(input int screen, input int wall, input int half);
    return screen - 1 - wall - half;
  endfunction
endpackage

// File: rtl/sprite_motion_ctrl_btn_sync.sv
// btn_sync: two-flop synchroniser for asynchronous button inputs
module btn_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) {q, meta} <= '0;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: button-driven sprite stepping with hold/auto-repeat, wall clamp and pixel hit
module sprite_motion_ctrl
  import sprite_motion_ctrl_pkg::*;
#(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int POS_W        = 10,
  parameter int HALF         = 10,
  parameter int WALL         = 6,
  parameter int STEP         = 2,
  parameter int TICK_DIV     = 2097152,
  parameter int REPEAT_TICKS = 8,
  parameter int INIT_X       = 100,
  parameter int INIT_Y       = 240
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             btn_u,
  input  logic             btn_d,
  input  logic             btn_l,
  input  logic             btn_r,
  input  logic             restart,
  input  logic             freeze,
  input  logic [POS_W-1:0] pix_x,
  input  logic [POS_W-1:0] pix_y,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y,
  output logic             moving,
  output logic             bump,
  output logic [15:0]      step_count,
  output logic             in_sprite
);
  localparam int W1 = POS_W + 1;
  localparam int TW = $clog2(TICK_DIV);
  localparam int HCW = $clog2(REPEAT_TICKS + 1);
  localparam logic [POS_W:0] LO_X = W1'(bound_lo(WALL, HALF));
  localparam logic [POS_W:0] HI_X = W1'(bound_hi(SCREEN_W, WALL, HALF));
  localparam logic [POS_W:0] LO_Y = W1'(bound_lo(WALL, HALF));
  localparam logic [POS_W:0] HI_Y = W1'(bound_hi(SCREEN_H, WALL, HALF));
  localparam logic [POS_W:0] PS = W1'(STEP);
  localparam logic signed [POS_W:0] HS = W1'(HALF);
  localparam logic [TW-1:0] TMAX = TW'(TICK_DIV - 1);
  localparam logic [HCW-1:0] RELOAD = HCW'(REPEAT_TICKS);
  logic [3:0] btn_s;
  dir_t dir, cur_dir, cur_dir_n;
  state_t state, state_n;
  logic [TW-1:0] tick_cnt;
  logic [HCW-1:0] hold_cnt, hold_n;
  logic tick, step, at_bound, vert, hit;
  logic [POS_W-1:0] nxt_x, nxt_y;
  logic signed [POS_W:0] dx, dy;
  // Extended-width compare keeps pos+STEP from wrapping before the clamp
  function automatic logic [POS_W-1:0] clamp_step(input logic [POS_W-1:0] p, input logic up,
                                                  input logic [POS_W:0] lo, input logic [POS_W:0] hi);
    return up ? (({1'b0, p} + PS > hi) ? hi[POS_W-1:0] : p + PS[POS_W-1:0])
              : (({1'b0, p} < lo + PS) ? lo[POS_W-1:0] : p - PS[POS_W-1:0]);
  endfunction
  btn_sync #(.W(4)) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d      ({btn_u, btn_d, btn_l, btn_r}),
    .q      (btn_s)
  );
  assign tick = tick_cnt == TMAX;
  assign moving = state != ST_IDLE;
  always_comb begin
    dir = btn_s == 4'b1000 ? DIR_U : btn_s == 4'b0100 ? DIR_D :
          btn_s == 4'b0010 ? DIR_L : btn_s == 4'b0001 ? DIR_R : DIR_NONE;
    vert = dir == DIR_U || dir == DIR_D;
    nxt_x = vert ? pos_x : clamp_step(pos_x, dir == DIR_R, LO_X, HI_X);
    nxt_y = vert ? clamp_step(pos_y, dir == DIR_D, LO_Y, HI_Y) : pos_y;
    at_bound = nxt_x == pos_x && nxt_y == pos_y;
    dx = $signed({1'b0, pix_x}) - $signed({1'b0, pos_x});
    dy = $signed({1'b0, pix_y}) - $signed({1'b0, pos_y});
    hit = dx >= -HS && dx <= HS && dy >= -HS && dy <= HS;
  end
  always_comb begin
    state_n = state;
    hold_n = hold_cnt;
    cur_dir_n = cur_dir;
    step = 1'b0;
    if (dir == DIR_NONE) state_n = ST_IDLE;
    else if (state == ST_IDLE || dir != cur_dir) begin
      step = 1'b1;
      hold_n = RELOAD;
      cur_dir_n = dir;
      state_n = ST_HOLD;
    end else if (state == ST_HOLD) begin
      hold_n = tick ? hold_cnt - 1'b1 : hold_cnt;
      state_n = tick && hold_cnt == HCW'(1) ? ST_REPEAT : ST_HOLD;
    end else step = tick;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      tick_cnt <= '0;
      state <= ST_IDLE;
      hold_cnt <= '0;
      cur_dir <= DIR_NONE;
      pos_x <= POS_W'(INIT_X);
      pos_y <= POS_W'(INIT_Y);
      bump <= 1'b0;
      step_count <= '0;
      in_sprite <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      state <= restart ? ST_IDLE : state_n;
      hold_cnt <= restart ? '0 : hold_n;
      cur_dir <= restart ? DIR_NONE : cur_dir_n;
      bump <= step && at_bound && !freeze && !restart;
      in_sprite <= hit;
      if (restart) begin
        pos_x <= POS_W'(INIT_X);
        pos_y <= POS_W'(INIT_Y);
      end else if (step && !freeze && !at_bound) begin
        pos_x <= nxt_x;
        pos_y <= nxt_y;
        step_count <= step_count + 1'b1;
      end
    end
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb_sprite_motion_ctrl: directed stimulus with a position-event scoreboard for sprite_motion_ctrl
module tb_sprite_motion_ctrl;
  logic clk = 0, reset_n = 1;
  logic btn_u = 0, btn_d = 0, btn_l = 0, btn_r = 0, restart = 0, freeze = 0;
  logic [9:0] pix_x = 0, pix_y = 0, pos_x, pos_y;
  logic moving, bump, in_sprite;
  logic [15:0] step_count;
  int cyc, checks, errors, lx, ly;
  typedef struct {int c; int x; int y; int b; int n;} ev_t;
  ev_t q[$];
  always #5 clk = ~clk;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else cyc <= cyc + 1;
  sprite_motion_ctrl #(.TICK_DIV(4), .REPEAT_TICKS(2)) dut (
    .clk(clk), .reset_n(reset_n), .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r),
    .restart(restart), .freeze(freeze), .pix_x(pix_x), .pix_y(pix_y), .pos_x(pos_x), .pos_y(pos_y),
    .moving(moving), .bump(bump), .step_count(step_count), .in_sprite(in_sprite)
  );
  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", nm, got, exp, cyc);
    end
  endtask
  task automatic ev(input int c, input int x, input int y, input int b, input int n);
    q.push_back('{c, x, y, b, n});
  endtask
  task automatic at(input int n);
    while (cyc < n) @(negedge clk);
  endtask
  task automatic chk_reset();
    chk("rst_pos_x", pos_x, 100);
    chk("rst_pos_y", pos_y, 240);
    chk("rst_moving", moving, 0);
    chk("rst_bump", bump, 0);
    chk("rst_step_count", step_count, 0);
    chk("rst_in_sprite", in_sprite, 0);
  endtask
  int px[7] = '{92, 91, 112, 113, 102, 102, 102};
  int py[7] = '{230, 230, 250, 240, 251, 229, 230};
  int ex[7] = '{1, 0, 1, 0, 0, 0, 1};
  initial begin
    fork
      forever begin
        ev_t e;
        @(negedge clk);
        if (!reset_n) begin
          lx = 100;
          ly = 240;
        end else if (pos_x != lx || pos_y != ly || bump) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: cyc %0d pos (%0d,%0d) bump %0d count %0d", cyc, pos_x, pos_y, bump, step_count);
          end else begin
            e = q.pop_front();
            if (cyc != e.c || pos_x != e.x || pos_y != e.y || bump != e.b || step_count != e.n) begin
              errors++;
              $display("FAIL event: got cyc %0d pos (%0d,%0d) bump %0d count %0d, expected cyc %0d pos (%0d,%0d) bump %0d count %0d",
                       cyc, pos_x, pos_y, bump, step_count, e.c, e.x, e.y, e.b, e.n);
            end
          end
          lx = pos_x;
          ly = pos_y;
        end
      end
    join_none
    #1 reset_n = 0;
    #11;
    chk_reset();
    ev(3, 102, 240, 0, 1); ev(12, 104, 240, 0, 2); ev(16, 106, 240, 0, 3); ev(20, 108, 240, 0, 4);
    reset_n = 1;
    btn_r = 1;
    at(3);  chk("first_step_x", pos_x, 102);
    at(5);  chk("moving_hold", moving, 1);
    at(21); btn_r = 0;
    at(23); chk("moving_before_idle", moving, 1);
    at(24); chk("moving_released", moving, 0);
    at(30); btn_l = 1; btn_u = 1;
    at(36); chk("two_btn_no_move", pos_x, 108); chk("two_btn_moving", moving, 0);
    ev(39, 106, 240, 0, 5);
    btn_u = 0;
    at(40); btn_l = 0;
    at(44);
    ev(47, 108, 240, 0, 6);
    for (int n = 1; n <= 257; n++) ev(52 + 4 * n, 108 + 2 * n, 240, 0, 6 + n);
    ev(1084, 623, 240, 0, 264); ev(1088, 623, 240, 1, 264);
    btn_r = 1;
    at(1089); btn_r = 0; chk("right_bound_count", step_count, 264);
    at(1096);
    ev(1099, 621, 240, 0, 265);
    for (int m = 1; m <= 302; m++) ev(1104 + 4 * m, 621 - 2 * m, 240, 0, 265 + m);
    ev(2316, 16, 240, 0, 568); ev(2320, 16, 240, 1, 568);
    btn_l = 1;
    at(2321); btn_l = 0; chk("left_bound_x", pos_x, 16); chk("left_bound_count", step_count, 568);
    at(2330); freeze = 1; btn_d = 1;
    at(2345); chk("frozen_y", pos_y, 240); chk("frozen_moving", moving, 1);
    at(2350); freeze = 0;
    ev(2352, 16, 242, 0, 569); ev(2356, 16, 244, 0, 570);
    at(2357); btn_d = 0;
    at(2364); btn_r = 1;
    ev(2367, 100, 240, 0, 570); ev(2368, 102, 240, 0, 571);
    at(2366); restart = 1;
    at(2367); restart = 0; chk("restart_idle", moving, 0);
    at(2368); btn_r = 0; chk("restart_restep", moving, 1);
    at(2380);
    for (int i = 0; i < 7; i++) begin
      pix_x = 10'(px[i]);
      pix_y = 10'(py[i]);
      @(negedge clk);
      chk($sformatf("in_sprite_%0d_%0d", px[i], py[i]), in_sprite, ex[i]);
    end
    at(2400); ev(2403, 102, 238, 0, 572); btn_u = 1;
    at(2403); btn_u = 0;
    at(2410); ev(2413, 104, 238, 0, 573); btn_r = 1; pix_x = 104; pix_y = 238;
    at(2414); chk("hit_before_reset", in_sprite, 1);
    at(2415);
    #2 reset_n = 0;
    #1 chk_reset();
    ev(3, 102, 240, 0, 1);
    repeat (3) @(negedge clk);
    reset_n = 1;
    at(2); chk("no_step_after_reset", pos_x, 100);
    at(3); chk("fresh_step_x", pos_x, 102); btn_r = 0;
    repeat (10) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
